// File: rtl/universal_shift_register.sv
// Parametrised universal shift register: hold / shift right / shift left / parallel load,
// with a word counter. Define USR_PARITY_EN to add the combinational parity output.
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] par_out,
  output logic             serial_out,
  output logic [CW-1:0]    shift_cnt,
  output logic             word_done
`ifdef USR_PARITY_EN
  , output logic           parity
`endif
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic             sout_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             done_nxt;
  logic             is_shift;
  logic             at_wrap;

  assign at_wrap = (shift_cnt == CW'(WIDTH - 1));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    sreg_nxt = sreg;
    sout_nxt = serial_out;
    cnt_nxt  = shift_cnt;
    done_nxt = 1'b0;
    is_shift = 1'b0;
    unique case (mode_e'(mode))
      MODE_HOLD: ;
      MODE_RIGHT: begin
        sreg_nxt = {sin_r, sreg[WIDTH-1:1]};
        sout_nxt = sreg[0];
        is_shift = 1'b1;
      end
      MODE_LEFT: begin
        sreg_nxt = {sreg[WIDTH-2:0], sin_l};
        sout_nxt = sreg[WIDTH-1];
        is_shift = 1'b1;
      end
      MODE_LOAD: begin
        sreg_nxt = par_in;
        cnt_nxt  = '0;
      end
      default: ;
    endcase
    // Direction never resets the count; only a load or a wrap does.
    if (is_shift) begin
      if (at_wrap) begin
        cnt_nxt  = '0;
        done_nxt = 1'b1;
      end else begin
        cnt_nxt  = shift_cnt + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg       <= '0;
      serial_out <= 1'b0;
      shift_cnt  <= '0;
      word_done  <= 1'b0;
    end else begin
      sreg       <= sreg_nxt;
      serial_out <= sout_nxt;
      shift_cnt  <= cnt_nxt;
      word_done  <= done_nxt;
    end
  end

  assign par_out = sreg;

`ifdef USR_PARITY_EN
  assign parity = ^sreg;
`endif

endmodule
